// File: rtl/via_bus_if.sv
// Request/response handshake plus adapter bus for the VIA register initiator.
// The master modport is the initiator's view. The slave modport is the requester/adapter view.
interface via_bus_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [3:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_error;
    logic [3:0] bus_register_select;
    logic       bus_chip_en;
    logic [7:0] bus_data_out;
    logic [7:0] bus_data_in;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, bus_data_in,
        output req_ready, rsp_valid, rsp_rdata, rsp_error,
               bus_register_select, bus_chip_en, bus_data_out
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, bus_data_in,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error,
               bus_register_select, bus_chip_en, bus_data_out
    );
endinterface

// File: rtl/via_bus_initiator.sv
// Single-outstanding initiator that turns register requests into timed chip-enable
// accesses on a VIA-style adapter. It keeps write shadows so that reads re-drive the last value.
module via_bus_initiator #(
    parameter int HOLD_CYCLES  = 1,
    parameter int READ_LATENCY = 1
) (
    input logic       clk,
    input logic       reset,
    via_bus_if.master bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [3:0]      hold_cnt_reg;
    logic [2:0]      wait_cnt_reg;
    logic            write_reg;
    logic [1:0]      addr_reg;
    logic [7:0]      wdata_reg;
    logic [7:0]      rdata_reg;
    logic            error_reg;
    logic [3:0]      sel_reg;
    logic [3:0][7:0] shadow;

    logic accept;
    logic addr_legal;
    logic access_done;
    logic wait_done;

    assign accept      = bus.req_valid && bus.req_ready;
    assign addr_legal  = (bus.req_addr[3:2] == 2'b00);
    assign access_done = (state_reg == ACCESS) && (hold_cnt_reg == 4'd0);
    assign wait_done   = (state_reg == WAIT) && (wait_cnt_reg == 3'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = addr_legal ? ACCESS : RESP;
            ACCESS:  if (access_done) state_next = write_reg ? RESP : WAIT;
            WAIT:    if (wait_done) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready           = 1'b0;
        bus.bus_chip_en         = 1'b0;
        bus.bus_data_out        = 8'h00;
        bus.bus_register_select = sel_reg;
        bus.rsp_valid           = 1'b0;
        bus.rsp_rdata           = 8'h00;
        bus.rsp_error           = 1'b0;
        case (state_reg)
            IDLE: bus.req_ready = !reset;
            ACCESS: begin
                bus.bus_chip_en  = 1'b1;
                bus.bus_data_out = write_reg ? wdata_reg : shadow[addr_reg];
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_rdata = rdata_reg;
                bus.rsp_error = error_reg;
            end
            default: ;
        endcase
    end

    // Request latch, access/wait counters and read-data capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt_reg <= 4'd0;
            wait_cnt_reg <= 3'd0;
            write_reg    <= 1'b0;
            addr_reg     <= 2'd0;
            wdata_reg    <= 8'h00;
            rdata_reg    <= 8'h00;
            error_reg    <= 1'b0;
            sel_reg      <= 4'd0;
        end else begin
            if (accept) begin
                write_reg    <= bus.req_write;
                addr_reg     <= bus.req_addr[1:0];
                wdata_reg    <= bus.req_wdata;
                rdata_reg    <= 8'h00;
                error_reg    <= !addr_legal;
                hold_cnt_reg <= 4'(HOLD_CYCLES - 1);
                if (addr_legal) begin
                    sel_reg <= bus.req_addr;
                end
            end
            if (state_reg == ACCESS) begin
                if (hold_cnt_reg != 4'd0) begin
                    hold_cnt_reg <= hold_cnt_reg - 4'd1;
                end else begin
                    wait_cnt_reg <= 3'(READ_LATENCY - 1);
                end
            end
            if (state_reg == WAIT) begin
                if (wait_cnt_reg != 3'd0) begin
                    wait_cnt_reg <= wait_cnt_reg - 3'd1;
                end else begin
                    rdata_reg <= bus.bus_data_in;
                end
            end
        end
    end

    // Shadows commit only when a write's access phase completes, so an aborted write leaves them untouched.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_shadow
            logic [7:0] value_reg;
            always_ff @(posedge clk) begin
                if (reset) begin
                    value_reg <= 8'h00;
                end else if (access_done && write_reg && (addr_reg == 2'(gi))) begin
                    value_reg <= wdata_reg;
                end
            end
            assign shadow[gi] = value_reg;
        end
    endgenerate
endmodule

// File: tb/tb_via_bus_initiator.sv
// Scoreboard bench for via_bus_initiator: two instances (HOLD/LAT = 1/1 and 3/4) share one stimulus path.
module tb_via_bus_initiator;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       dut_sel;
    logic       tb_valid;
    logic       tb_write;
    logic [3:0] tb_addr;
    logic [7:0] tb_wdata;
    logic [7:0] tb_din;

    via_bus_if ifa ();
    via_bus_if ifb ();

    assign ifa.req_valid   = tb_valid && !dut_sel;
    assign ifa.req_write   = tb_write;
    assign ifa.req_addr    = tb_addr;
    assign ifa.req_wdata   = tb_wdata;
    assign ifa.bus_data_in = tb_din;
    assign ifb.req_valid   = tb_valid && dut_sel;
    assign ifb.req_write   = tb_write;
    assign ifb.req_addr    = tb_addr;
    assign ifb.req_wdata   = tb_wdata;
    assign ifb.bus_data_in = tb_din;

    via_bus_initiator #(.HOLD_CYCLES(1), .READ_LATENCY(1)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
    via_bus_initiator #(.HOLD_CYCLES(3), .READ_LATENCY(4)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

    logic       obs_ready, obs_ce, obs_rsp_valid, obs_rsp_error;
    logic [3:0] obs_sel;
    logic [7:0] obs_dout, obs_rdata;
    assign obs_ready     = dut_sel ? ifb.req_ready : ifa.req_ready;
    assign obs_ce        = dut_sel ? ifb.bus_chip_en : ifa.bus_chip_en;
    assign obs_sel       = dut_sel ? ifb.bus_register_select : ifa.bus_register_select;
    assign obs_dout      = dut_sel ? ifb.bus_data_out : ifa.bus_data_out;
    assign obs_rsp_valid = dut_sel ? ifb.rsp_valid : ifa.rsp_valid;
    assign obs_rdata     = dut_sel ? ifb.rsp_rdata : ifa.rsp_rdata;
    assign obs_rsp_error = dut_sel ? ifb.rsp_error : ifa.rsp_error;

    typedef struct {
        int         cycle;
        logic       err;
        logic [7:0] rdata;
    } exp_t;
    exp_t sb_q[$];

    int         vectors = 0;
    int         miscompares = 0;
    int         hold_p[2] = '{1, 3};
    int         lat_p[2]  = '{1, 4};
    logic [7:0] sh_model[2][4];
    logic [3:0] last_sel[2];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_models();
        for (int d = 0; d < 2; d++) begin
            last_sel[d] = 4'd0;
            for (int r = 0; r < 4; r++) sh_model[d][r] = 8'h00;
        end
    endtask

    task automatic run_txn(input int d, input logic w, input logic [3:0] a, input logic [7:0] wd,
                           input logic [7:0] din, input bit keep_valid);
        exp_t       e;
        exp_t       got_e;
        int         h, l, exp_ce, ce_seen, rsp_cycle;
        logic [7:0] exp_dout;
        bit         done;
        h = hold_p[d];
        l = lat_p[d];
        @(negedge clk);
        dut_sel  = d[0];
        tb_valid = 1'b1;
        tb_write = w;
        tb_addr  = a;
        tb_wdata = wd;
        tb_din   = ~din;
        #1;
        check_val("idle_ready", obs_ready, 1);
        e.err   = (a > 4'd3);
        e.rdata = (w || e.err) ? 8'h00 : din;
        e.cycle = e.err ? 1 : (w ? h + 1 : h + l + 1);
        sb_q.push_back(e);
        exp_ce   = e.err ? 0 : h;
        exp_dout = w ? wd : sh_model[d][a[1:0]];
        ce_seen   = 0;
        rsp_cycle = 0;
        done      = 0;
        for (int k = 1; k <= 40 && !done; k++) begin
            @(negedge clk);
            check_val("busy_ready", obs_ready, 0);
            if (obs_ce) begin
                ce_seen++;
                check_val("access_sel", obs_sel, a);
                check_val("access_dout", obs_dout, exp_dout);
            end else begin
                check_val("quiet_dout", obs_dout, 0);
            end
            if (obs_rsp_valid) begin
                got_e = sb_q.pop_front();
                rsp_cycle = k;
                check_val("rsp_cycle", k, got_e.cycle);
                check_val("rsp_rdata", obs_rdata, got_e.rdata);
                check_val("rsp_error", obs_rsp_error, got_e.err);
                check_val("ce_cycles", ce_seen, exp_ce);
                if (!e.err) last_sel[d] = a;
                check_val("sel_hold", obs_sel, last_sel[d]);
                if (w && !e.err) sh_model[d][a[1:0]] = wd;
                if (!keep_valid) tb_valid = 1'b0;
                done = 1;
            end else begin
                check_val("quiet_rsp", {obs_rsp_error, obs_rdata}, 0);
            end
            // Scramble the held request so any leak onto the bus is visible.
            tb_write = 1'($urandom_range(0, 1));
            tb_addr  = 4'($urandom_range(0, 15));
            tb_wdata = 8'($urandom_range(0, 255));
            tb_din   = (k == h + l) ? din : ~din;
        end
        if (!done) begin
            check_val("rsp_timeout", 0, 1);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
            tb_valid = 1'b0;
        end
        $display("txn dut=%0d %s addr=%0d wdata=0x%02h din=0x%02h rsp_cycle=%0d ce_cycles=%0d",
                 d, w ? "WR" : "RD", a, wd, din, rsp_cycle, ce_seen);
    endtask

    task automatic reset_mid_write();
        @(negedge clk);
        dut_sel  = 1'b1;
        tb_valid = 1'b1;
        tb_write = 1'b1;
        tb_addr  = 4'd2;
        tb_wdata = 8'h33;
        repeat (3) @(negedge clk);
        check_val("abort_pre_ce", obs_ce, 1);
        tb_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        check_val("abort_ce", obs_ce, 0);
        check_val("abort_rsp", obs_rsp_valid, 0);
        check_val("abort_ready", obs_ready, 0);
        check_val("abort_sel", obs_sel, 0);
        reset = 1'b0;
        clear_models();
        #1;
        check_val("release_ready", obs_ready, 1);
        @(negedge clk);
        check_val("release_rsp", obs_rsp_valid, 0);
        check_val("release_ready2", obs_ready, 1);
        $display("txn dut=1 WR addr=2 wdata=0x33 aborted by reset");
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        dut_sel  = 1'b0;
        tb_valid = 1'b0;
        tb_write = 1'b0;
        tb_addr  = 4'd0;
        tb_wdata = 8'h00;
        tb_din   = 8'h00;
        clear_models();
        repeat (3) @(negedge clk);
        check_val("rst_ready", obs_ready, 0);
        check_val("rst_ce", obs_ce, 0);
        check_val("rst_sel", obs_sel, 0);
        check_val("rst_dout", obs_dout, 0);
        check_val("rst_rsp", {obs_rsp_valid, obs_rsp_error, obs_rdata}, 0);
        reset = 1'b0;
        @(negedge clk);
        check_val("post_rst_ready", obs_ready, 1);

        run_txn(0, 1'b1, 4'd3,  8'hFF, 8'h00, 0);
        run_txn(0, 1'b1, 4'd1,  8'h5A, 8'h00, 0);
        run_txn(0, 1'b0, 4'd1,  8'h00, 8'hA5, 0);
        run_txn(0, 1'b0, 4'd9,  8'h00, 8'h77, 0);
        run_txn(0, 1'b1, 4'd15, 8'hEE, 8'h00, 0);
        run_txn(0, 1'b1, 4'd0,  8'h11, 8'h00, 1);
        run_txn(0, 1'b0, 4'd0,  8'h00, 8'h3C, 1);
        run_txn(0, 1'b1, 4'd2,  8'h77, 8'h00, 0);
        run_txn(1, 1'b1, 4'd1,  8'h42, 8'h00, 0);
        run_txn(1, 1'b0, 4'd1,  8'h00, 8'h96, 0);
        run_txn(1, 1'b0, 4'd3,  8'h00, 8'hC3, 1);
        run_txn(1, 1'b1, 4'd12, 8'h99, 8'h00, 0);
        reset_mid_write();
        run_txn(1, 1'b0, 4'd2,  8'h00, 8'h5E, 0);
        run_txn(0, 1'b0, 4'd3,  8'h00, 8'h10, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/via_bus_initiator.md
VIA_BUS_INITIATOR -- requirements
Module: via_bus_initiator

Interface
REQ-001 Parameter HOLD_CYCLES, default 1, number of cycles bus_chip_en is held per access; legal range 1..15.
REQ-002 Parameter READ_LATENCY, default 1, cycles from the last chip-enable cycle to the read-data sample; legal range 1..7.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  initiator can accept a request this cycle.
REQ-007 req_write  input  1  1=write, 0=read.
REQ-008 req_addr  input  4  target register select.
REQ-009 req_wdata  input  8  write data.
REQ-010 rsp_valid  output  1  one-cycle completion pulse.
REQ-011 rsp_rdata  output  8  read data; 0 for writes and errors.
REQ-012 rsp_error  output  1  request addressed a nonexistent register; qualified by rsp_valid.
REQ-013 bus_register_select  output  4  register select driven to the adapter.
REQ-014 bus_chip_en  output  1  adapter chip enable.
REQ-015 bus_data_out  output  8  data driven to the adapter data input.
REQ-016 bus_data_in  input  8  data returned from the adapter data output.

Function
REQ-017 The FSM SHALL have four states: IDLE, ACCESS, WAIT and RESP.
REQ-018 req_ready SHALL be 1 only in IDLE while reset is low; a request is accepted on an edge where req_valid and req_ready are both 1.
REQ-019 On acceptance the block SHALL latch req_write, req_addr and req_wdata; request inputs SHALL be ignored in every other state.
REQ-020 Register addresses 0 to 3 (ORB_IRB, ORA_IRA, DDRB, DDRA) are legal; addresses 4 to 15 SHALL move IDLE->RESP with rsp_error=1, rsp_rdata=0, and no bus activity.
REQ-021 For a legal address, IDLE SHALL move to ACCESS, which SHALL last exactly HOLD_CYCLES cycles, counted by a 4-bit down-counter.
REQ-022 In ACCESS the outputs SHALL be bus_chip_en=1 and bus_register_select=latched address.
REQ-023 In ACCESS, bus_data_out SHALL be the latched wdata for a write, and shadow[addr] for a read, so that a read re-drives the last written value.
REQ-024 The block SHALL keep four 8-bit shadow registers; shadow[addr] SHALL load the latched wdata on the edge that ends the final ACCESS cycle of a write.
REQ-025 After ACCESS, a write SHALL go to RESP and a read SHALL go to WAIT.
REQ-026 WAIT SHALL last READ_LATENCY cycles, counted by a 3-bit down-counter.
REQ-027 bus_data_in SHALL be sampled into rsp_rdata on the edge ending the final WAIT cycle, then WAIT SHALL move to RESP.
REQ-028 Outside ACCESS, bus_chip_en SHALL be 0 and bus_data_out SHALL be 0.
REQ-029 Outside ACCESS, bus_register_select SHALL hold its last driven value.
REQ-030 RESP SHALL last one cycle with rsp_valid=1, then return to IDLE; responses SHALL NOT be back-pressured.
REQ-031 rsp_valid, rsp_rdata and rsp_error SHALL be 0 in every state except RESP.
REQ-032 Timing SHALL be measured in cycles after the acceptance edge; rsp_valid SHALL be high in cycle:
- HOLD_CYCLES+1 for a write;
- HOLD_CYCLES+READ_LATENCY+1 for a read;
- 1 for an error.
REQ-033 Only one request SHALL be outstanding at a time; back-to-back requests SHALL be separated by at least one IDLE cycle.
REQ-034 req_valid asserted while req_ready=0 SHALL have no effect; the requester holds the request until it is accepted.
REQ-035 All outputs SHALL be registered or decoded from the registered state only, with no combinational path from request inputs to bus outputs.

Reset
REQ-036 While reset is high the block SHALL set:
- state=IDLE and both counters=0;
- all shadows=0;
- bus_chip_en=0, bus_data_out=0, bus_register_select=0;
- req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_error=0.
REQ-037 Reset asserted mid-transaction SHALL abort it: no rsp_valid is produced and no shadow update occurs; bus_chip_en SHALL be 0 in the cycle after the reset edge.
REQ-038 req_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-039 Write DDRA=0xFF, with HOLD=1 -> one cycle of chip_en=1, sel=3, data_out=0xFF; rsp_valid in cycle 2 with rdata=0, error=0.
REQ-040 Write ORA=0x5A, then read ORA with the adapter returning 0xA5 and READ_LATENCY=1 -> the read drives data_out=0x5A, rsp_rdata=0xA5, and rsp_valid in cycle 3.
REQ-041 Request to addr=9 -> no chip_en pulse; rsp_valid in cycle 1 with error=1, rdata=0.
REQ-042 HOLD=3, READ_LATENCY=4 read -> chip_en high for exactly 3 cycles; rsp_valid in cycle 8; sample taken at the end of cycle 7.
REQ-043 Reset asserted during ACCESS of a write to DDRB=0x33 -> chip_en 0 next cycle, no rsp_valid, shadow[DDRB]=0, and req_ready=1 after release.
REQ-044 req_valid held continuously with changing data during a transaction -> only the accepted request's values appear on the bus; the next acceptance occurs in the first IDLE cycle.
